// File: rtl/fp_wb_pkg.sv
// Shared types and sizing helpers for the FP register-file write-back controller.
package fp_wb_pkg;

    // Widest FP register supported (D extension); narrower configurations truncate.
    localparam int unsigned MaxDataWidth = 64;

    function automatic int unsigned addr_width(bit rv32e);
        return rv32e ? 4 : 5;
    endfunction

    typedef enum logic {
        WB_SRC_FPU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [4:0]              addr;
        logic [MaxDataWidth-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/fp_wb_rr_arb.sv
// Two-way round-robin arbiter between FPU (req[0]) and LSU (req[1]) results.
module fp_wb_rr_arb
    import fp_wb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e last_grant_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == WB_SRC_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= WB_SRC_LSU;
        end else if (|gnt) begin
            last_grant_q <= gnt[1] ? WB_SRC_LSU : WB_SRC_FPU;
        end
    end

endmodule

// File: rtl/fp_regfile_wb_ctrl.sv
// FP register-file write port controller: FPU/LSU arbitration, registered write port,
// per-register pending-write scoreboard for ID-stage hazard checks.
module fp_regfile_wb_ctrl
    import fp_wb_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    input  logic [4:0]           issue_waddr_i,
    output logic                 issue_ready_o,
    input  logic [4:0]           chk_addr_a_i,
    input  logic [4:0]           chk_addr_b_i,
    input  logic [4:0]           chk_addr_c_i,
    output logic                 hazard_o,
    input  logic                 fpu_valid_i,
    input  logic [4:0]           fpu_waddr_i,
    input  logic [DataWidth-1:0] fpu_wdata_i,
    output logic                 fpu_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_ready_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 err_o
);

    localparam int unsigned AddrWidth = addr_width(RV32E);
    localparam int unsigned NumWords  = 1 << AddrWidth;

    typedef logic [AddrWidth-1:0] idx_t;

    logic [NumWords-1:1] busy_q;
    logic [NumWords-1:0] busy_vec;
    logic [1:0]          gnt;
    logic                grant_any;
    logic                issue_fire;
    logic                err_hit;
    wb_req_t             fpu_req;
    wb_req_t             lsu_req;
    wb_req_t             sel_req;
    idx_t                issue_idx;
    idx_t                sel_idx;
    idx_t                wr_idx;

    // Address 0 reads as never busy.
    assign busy_vec  = {busy_q, 1'b0};
    assign issue_idx = idx_t'(issue_waddr_i);
    assign wr_idx    = idx_t'(rf_waddr_o);

    assign issue_ready_o = ~busy_vec[issue_idx];
    assign issue_fire    = issue_valid_i & issue_ready_o;
    assign hazard_o      = busy_vec[idx_t'(chk_addr_a_i)]
                         | busy_vec[idx_t'(chk_addr_b_i)]
                         | busy_vec[idx_t'(chk_addr_c_i)];

    fp_wb_rr_arb u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    ({lsu_valid_i, fpu_valid_i}),
        .gnt    (gnt)
    );

    assign fpu_ready_o = gnt[0];
    assign lsu_ready_o = gnt[1];
    assign grant_any   = |gnt;

    assign fpu_req = '{addr: fpu_waddr_i, data: MaxDataWidth'(fpu_wdata_i)};
    assign lsu_req = '{addr: lsu_waddr_i, data: MaxDataWidth'(lsu_wdata_i)};
    assign sel_req = gnt[1] ? lsu_req : fpu_req;
    assign sel_idx = idx_t'(sel_req.addr);

    // A result is unexpected if nothing is pending, or if the previous grant already
    // serviced this register (its busy bit is only cleared at the upcoming write edge).
    assign err_hit = grant_any && (sel_idx != '0)
                  && (!busy_vec[sel_idx] || (rf_we_o && (wr_idx == sel_idx)));

    // NOTE: with non-blocking assignments the last write to a bit in the block wins,
    // so placing the set after the clear gives set priority on a same-register collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            if (rf_we_o && (wr_idx != '0)) begin
                busy_q[wr_idx] <= 1'b0;
            end
            if (issue_fire && (issue_idx != '0)) begin
                busy_q[issue_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            rf_we_o <= grant_any;
            if (grant_any) begin
                rf_waddr_o <= 5'(sel_idx);
                rf_wdata_o <= DataWidth'(sel_req.data);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (err_hit) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_regfile_wb_ctrl.sv
// Self-checking bench for fp_regfile_wb_ctrl: arbitration vector table, write-port
// scoreboard, and hand-written hazard / error / reset sequences.
module tb_fp_regfile_wb_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic [4:0]  issue_waddr_i;
    logic        issue_ready_o;
    logic [4:0]  chk_addr_a_i, chk_addr_b_i, chk_addr_c_i;
    logic        hazard_o;
    logic        fpu_valid_i, lsu_valid_i;
    logic [4:0]  fpu_waddr_i, lsu_waddr_i;
    logic [31:0] fpu_wdata_i, lsu_wdata_i;
    logic        fpu_ready_o, lsu_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit         fv;
        bit         lv;
        logic [4:0] fa;
        logic [4:0] la;
        bit         exp_f;
        bit         exp_l;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    always #5 clk_i = ~clk_i;

    fp_regfile_wb_ctrl #(.DataWidth(32), .RV32E(1'b0)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (issue_valid_i),
        .issue_waddr_i (issue_waddr_i),
        .issue_ready_o (issue_ready_o),
        .chk_addr_a_i  (chk_addr_a_i),
        .chk_addr_b_i  (chk_addr_b_i),
        .chk_addr_c_i  (chk_addr_c_i),
        .hazard_o      (hazard_o),
        .fpu_valid_i   (fpu_valid_i),
        .fpu_waddr_i   (fpu_waddr_i),
        .fpu_wdata_i   (fpu_wdata_i),
        .fpu_ready_o   (fpu_ready_o),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_waddr_i   (lsu_waddr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_ready_o   (lsu_ready_o),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .err_o         (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write-port monitor: every cycle with rf_we_o high must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_ni && rf_we_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got write addr %0d data 0x%0h, expected none",
                         rf_waddr_o, rf_wdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_addr", 32'(rf_waddr_o), 32'(e.addr));
                check("wb_data", rf_wdata_o, e.data);
            end
        end
    end

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        issue_valid_i = 1'b0;
        issue_waddr_i = '0;
        chk_addr_a_i  = '0;
        chk_addr_b_i  = '0;
        chk_addr_c_i  = '0;
        fpu_valid_i   = 1'b0;
        fpu_waddr_i   = '0;
        fpu_wdata_i   = '0;
        lsu_valid_i   = 1'b0;
        lsu_waddr_i   = '0;
        lsu_wdata_i   = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic issue(input logic [4:0] a);
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b1;
        issue_waddr_i = a;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{fv: 1, lv: 1, fa: 5'd1, la: 5'd11, exp_f: 1, exp_l: 0};
        vecs[1] = '{fv: 0, lv: 1, fa: 5'd0, la: 5'd11, exp_f: 0, exp_l: 1};
        vecs[2] = '{fv: 1, lv: 0, fa: 5'd2, la: 5'd0,  exp_f: 1, exp_l: 0};
        vecs[3] = '{fv: 1, lv: 1, fa: 5'd3, la: 5'd12, exp_f: 0, exp_l: 1};
        vecs[4] = '{fv: 1, lv: 0, fa: 5'd3, la: 5'd0,  exp_f: 1, exp_l: 0};
        vecs[5] = '{fv: 0, lv: 0, fa: 5'd0, la: 5'd0,  exp_f: 0, exp_l: 0};
        vecs[6] = '{fv: 1, lv: 1, fa: 5'd4, la: 5'd13, exp_f: 0, exp_l: 1};
        vecs[7] = '{fv: 1, lv: 0, fa: 5'd4, la: 5'd0,  exp_f: 1, exp_l: 0};

        clear_inputs();
        do_reset();

        // Reset state.
        #1;
        issue_waddr_i = 5'd5;
        chk_addr_a_i  = 5'd5;
        #1;
        check("rst_issue_ready", issue_ready_o, 1);
        check("rst_hazard", hazard_o, 0);
        check("rst_rf_we", rf_we_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rf_waddr", 32'(rf_waddr_o), 0);

        // Single FPU result through the pipeline.
        issue(5'd5);
        @(negedge clk_i);
        check("issue5_ready", issue_ready_o, 1);
        check("issue5_hazard_pre", hazard_o, 0);
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
        fpu_valid_i   = 1'b1;
        fpu_waddr_i   = 5'd5;
        fpu_wdata_i   = 32'h3F80_0000;
        push_exp(5'd5, 32'h3F80_0000);
        @(negedge clk_i);
        check("issue5_hazard", hazard_o, 1);
        check("fpu5_ready", fpu_ready_o, 1);
        @(posedge clk_i);
        #1;
        fpu_valid_i = 1'b0;
        @(negedge clk_i);
        check("fpu5_we", rf_we_o, 1);
        check("fpu5_hazard_until_write", hazard_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("fpu5_hazard_clear", hazard_o, 0);
        check("fpu5_we_low", rf_we_o, 0);

        // FPU/LSU tie right after reset: FPU first, LSU next cycle.
        do_reset();
        issue(5'd7);
        issue(5'd9);
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
        fpu_valid_i   = 1'b1;
        fpu_waddr_i   = 5'd7;
        fpu_wdata_i   = 32'h4000_0000;
        lsu_valid_i   = 1'b1;
        lsu_waddr_i   = 5'd9;
        lsu_wdata_i   = 32'h4040_0000;
        push_exp(5'd7, 32'h4000_0000);
        push_exp(5'd9, 32'h4040_0000);
        @(negedge clk_i);
        check("tie_fpu_ready", fpu_ready_o, 1);
        check("tie_lsu_ready", lsu_ready_o, 0);
        @(posedge clk_i);
        #1;
        fpu_valid_i = 1'b0;
        @(negedge clk_i);
        check("tie_lsu_ready2", lsu_ready_o, 1);
        check("tie_we_1", rf_we_o, 1);
        @(posedge clk_i);
        #1;
        lsu_valid_i  = 1'b0;
        chk_addr_a_i = 5'd7;
        chk_addr_b_i = 5'd9;
        @(negedge clk_i);
        check("tie_we_2", rf_we_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("tie_we_low", rf_we_o, 0);
        check("tie_hazard_clear", hazard_o, 0);

        // Arbitration vector table.
        do_reset();
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        issue(5'd4);
        issue(5'd11);
        issue(5'd12);
        issue(5'd13);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            issue_valid_i = 1'b0;
            fpu_valid_i   = vecs[i].fv;
            fpu_waddr_i   = vecs[i].fa;
            fpu_wdata_i   = 32'h1000_0000 | 32'(vecs[i].fa);
            lsu_valid_i   = vecs[i].lv;
            lsu_waddr_i   = vecs[i].la;
            lsu_wdata_i   = 32'h2000_0000 | 32'(vecs[i].la);
            if (vecs[i].exp_f) push_exp(vecs[i].fa, 32'h1000_0000 | 32'(vecs[i].fa));
            if (vecs[i].exp_l) push_exp(vecs[i].la, 32'h2000_0000 | 32'(vecs[i].la));
            @(negedge clk_i);
            check($sformatf("vec%0d_fpu_ready", i), fpu_ready_o, 32'(vecs[i].exp_f));
            check($sformatf("vec%0d_lsu_ready", i), lsu_ready_o, 32'(vecs[i].exp_l));
        end
        @(posedge clk_i);
        #1;
        fpu_valid_i  = 1'b0;
        lsu_valid_i  = 1'b0;
        chk_addr_a_i = 5'd1;
        chk_addr_b_i = 5'd11;
        chk_addr_c_i = 5'd4;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("vec_hazard_drained", hazard_o, 0);
        check("vec_err", err_o, 0);

        // Re-issue of a pending destination stalls until the write edge.
        chk_addr_a_i = 5'd3;
        issue(5'd3);
        @(negedge clk_i);
        check("reissue_first", issue_ready_o, 1);
        @(posedge clk_i);
        #1;
        fpu_valid_i = 1'b1;
        fpu_waddr_i = 5'd3;
        fpu_wdata_i = 32'h0000_0333;
        push_exp(5'd3, 32'h0000_0333);
        @(negedge clk_i);
        check("reissue_blocked", issue_ready_o, 0);
        @(posedge clk_i);
        #1;
        fpu_valid_i = 1'b0;
        @(negedge clk_i);
        check("reissue_blocked_write_pending", issue_ready_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("reissue_ready_after_write", issue_ready_o, 1);
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
        @(negedge clk_i);
        check("reissue_hazard", hazard_o, 1);

        // LSU result for a register with no pending write: sticky error, write still emitted.
        @(posedge clk_i);
        #1;
        lsu_valid_i = 1'b1;
        lsu_waddr_i = 5'd12;
        lsu_wdata_i = 32'hDEAD_BEEF;
        push_exp(5'd12, 32'hDEAD_BEEF);
        @(negedge clk_i);
        check("stray_lsu_ready", lsu_ready_o, 1);
        check("stray_err_before", err_o, 0);
        @(posedge clk_i);
        #1;
        lsu_valid_i = 1'b0;
        @(negedge clk_i);
        check("stray_err", err_o, 1);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("stray_err_sticky", err_o, 1);

        // Two consecutive results to the same pending register.
        do_reset();
        #1;
        check("dbl_err_reset", err_o, 0);
        issue(5'd6);
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
        fpu_valid_i   = 1'b1;
        fpu_waddr_i   = 5'd6;
        fpu_wdata_i   = 32'h0000_0066;
        push_exp(5'd6, 32'h0000_0066);
        @(posedge clk_i);
        #1;
        fpu_valid_i = 1'b0;
        lsu_valid_i = 1'b1;
        lsu_waddr_i = 5'd6;
        lsu_wdata_i = 32'h0000_0077;
        push_exp(5'd6, 32'h0000_0077);
        @(negedge clk_i);
        check("dbl_err_before", err_o, 0);
        @(posedge clk_i);
        #1;
        lsu_valid_i = 1'b0;
        @(negedge clk_i);
        check("dbl_err", err_o, 1);

        // Reset asserted with a pending bit and an in-flight write.
        do_reset();
        chk_addr_c_i = 5'd4;
        issue(5'd4);
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
        fpu_valid_i   = 1'b1;
        fpu_waddr_i   = 5'd4;
        fpu_wdata_i   = 32'h0000_0044;
        @(posedge clk_i);
        #1;
        fpu_valid_i = 1'b0;
        check("midrst_we_inflight", rf_we_o, 1);
        check("midrst_hazard_pending", hazard_o, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst_we_dropped", rf_we_o, 0);
        check("midrst_hazard", hazard_o, 0);
        issue_waddr_i = 5'd4;
        #1;
        check("midrst_issue_ready", issue_ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_hazard_after", hazard_o, 0);
        check("midrst_we_after", rf_we_o, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_regfile_wb_ctrl.md
# fp_regfile_wb_ctrl

Write-side controller for the floating-point register file. It arbitrates FPU results and FP load data onto the register file's single write port. It keeps a per-register pending-write scoreboard so the ID stage can stall on RAW/WAW hazards against the three FP read ports. It sits between the FPU/LSU result paths and the register file's write port W1.

## Interface
Parameters:
- DataWidth, 32, width of FP register data.
- RV32E, 0, when 1 only addresses 0-15 exist (ADDR_WIDTH 4); otherwise 0-31.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  ID stage issues an instruction that writes an FP register.
- issue_waddr_i  in  5  destination of the issuing instruction.
- issue_ready_o  out  1  issue accepted (destination not pending).
- chk_addr_a_i / chk_addr_b_i / chk_addr_c_i  in  5 each  source addresses of the instruction in ID.
- hazard_o  out  1  any checked source has a pending write.
- fpu_valid_i, fpu_waddr_i[4:0], fpu_wdata_i[DataWidth-1:0]  in  FPU result request.
- fpu_ready_o  out  1  FPU result accepted this cycle.
- lsu_valid_i, lsu_waddr_i[4:0], lsu_wdata_i[DataWidth-1:0]  in  FP load result request.
- lsu_ready_o  out  1  LSU result accepted this cycle.
- rf_we_o, rf_waddr_o[4:0], rf_wdata_o[DataWidth-1:0]  out  registered write port to the FP register file.
- err_o  out  1  sticky: a result arrived for a register with no pending write.

## Operation
- Scoreboard: busy[NUM_WORDS-1:1] flops. Address 0 has no busy bit; a check against address 0 is never a hazard.
- Issue:
  - issue_ready_o = !busy[issue_waddr_i]; it is 1 for address 0.
  - On issue_valid_i && issue_ready_o, busy[issue_waddr_i] is set at the clock edge (skipped for address 0).
- Hazard: hazard_o = busy[chk_addr_a_i] | busy[chk_addr_b_i] | busy[chk_addr_c_i]. It is combinational and uses current flop state only.
- Arbitration uses a 2-way round-robin (fp_wb_rr_arb).
  - A single valid requester is granted.
  - If both are valid, grant goes to the source not granted last.
  - last_grant updates only on a grant. Its reset value is LSU, so the FPU wins the first tie.
  - fpu_ready_o / lsu_ready_o equal the grant. The output stage always drains, so a valid request never waits more than one cycle.
- Output stage: on a grant, rf_we_o/rf_waddr_o/rf_wdata_o load the granted request at the edge. With no grant, rf_we_o loads 0 and addr/data hold.
- Clear: busy[rf_waddr_o] clears at the edge where rf_we_o=1, which is the same edge on which the register file captures the data. hazard_o therefore drops exactly when the data is readable.
- Simultaneous set and clear of the same register cannot occur, because the busy bit blocks issue. The implementation gives set priority anyway.
- err_o:
  - Set when a granted request's address is nonzero and its busy bit is 0.
  - Set when two results target the same busy register in consecutive grants without an intervening issue.
  - Cleared only by reset. The write is still performed.
- Address bits above ADDR_WIDTH are ignored when RV32E=1.

## Timing
- Reset values:
  - busy all 0.
  - rf_we_o 0, rf_waddr_o 0, rf_wdata_o 0.
  - err_o 0.
  - last_grant LSU.
  - Consequently issue_ready_o=1, hazard_o=0, and both ready outputs follow their valid inputs.
- Latency, grant edge to rf_we_o high: 1 cycle.
- Latency, result handshake to hazard_o low: 2 edges (grant edge, then write edge).
- Throughput: one result per cycle total.
- Handshake rules:
  - Sources hold valid, addr and data stable until ready.
  - Ready depends combinationally on valid; it never depends on ready.
- Reset asserted mid-operation: all pending bits are lost, and an in-flight output write is dropped (rf_we_o goes to 0 asynchronously).

## Structure
- Package fp_wb_pkg:
  - ADDR_WIDTH function of RV32E.
  - typedef wb_src_e {WB_SRC_FPU, WB_SRC_LSU}.
  - typedef wb_req_t {addr, data}.
- Sub-module fp_wb_rr_arb:
  - Contents: 2-input round-robin arbiter with the last_grant flop.
  - Inputs: req[1:0]. Outputs: gnt[1:0] (one-hot or zero).
- The top holds the scoreboard, the output register and err_o.

## Test plan
- Reset, then probe: issue_ready_o=1, hazard_o=0, rf_we_o=0, err_o=0.
- Issue waddr 5, then check a=5 next cycle -> hazard_o=1. FPU result {5, 0x3F800000}:
  - fpu_ready_o=1 same cycle.
  - rf_we_o=1 / waddr 5 / wdata 0x3F800000 next cycle.
  - hazard_o=0 the cycle after.
- Issue 7 and 9; FPU {7} and LSU {9} valid in the same cycle -> FPU granted first, LSU one cycle later; rf_we_o stays high 2 consecutive cycles.
- Issue 3, then issue 3 again -> second issue_ready_o=0 until the write edge for 3, then 1.
- LSU result to address 12 with no issue -> err_o=1 and stays high; the write is still emitted.
- Issue 4, assert rst_ni=0 mid-flight -> busy cleared, hazard_o=0 on check c=4, rf_we_o=0.
